// File: rtl/nmr_seq_pkg.sv
// nmr_seq_pkg: shared state encoding and size defaults for the NMR pulse sequencer
package nmr_seq_pkg;

    localparam int N_PULSES_MAX     = 3;
    localparam int DEF_CNT_W        = 32;
    localparam int DEF_SCAN_W       = 16;
    localparam int DEF_BLANK_CYCLES = 16;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        PULSE,
        PDLY,
        BLANK,
        ACQ,
        REP,
        DONE
    } state_t;

    // States whose duration is measured by the shared down-counter
    function automatic logic is_timed(input state_t s);
        return (s == PULSE) || (s == PDLY) || (s == BLANK) || (s == ACQ) || (s == REP);
    endfunction

endpackage

// File: rtl/seq_timer.sv
// seq_timer: loadable down-counter shared by all timed sequencer states
module seq_timer #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] len,
    output logic         expire
);

    logic [W-1:0] cnt;

    // Load promotes a zero length to one so every timed state lasts at least a cycle
    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= (len == '0) ? W'(1) : len;
        else if (cnt > W'(1))
            cnt <= cnt - W'(1);
    end

    assign expire = (cnt == W'(1));

endmodule

// File: rtl/nmr_pulse_sequencer.sv
// nmr_pulse_sequencer: multi-pulse NMR scan sequencer; RX_BLANK_EN adds a receiver blanking state before ACQ
module nmr_pulse_sequencer
    import nmr_seq_pkg::*;
#(
    parameter int CNT_W        = DEF_CNT_W,
    parameter int SCAN_W       = DEF_SCAN_W,
    parameter int BLANK_CYCLES = DEF_BLANK_CYCLES
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      abort,
    input  logic                      dds_valid,
    input  logic [1:0]                n_pulses,
    input  logic [3*CNT_W-1:0]        pulse_len,
    input  logic [3*CNT_W-1:0]        pulse_dly,
    input  logic [CNT_W-1:0]          acq_len,
    input  logic [CNT_W-1:0]          rep_dly,
    input  logic [SCAN_W-1:0]         n_scans,
    output logic                      enable_gen,
    output logic [1:0]                TX_active_phase,
    output logic                      rx_gate,
    output logic                      busy,
    output logic                      done,
    output logic [SCAN_W-1:0]         scan_count
);

`ifdef RX_BLANK_EN
    localparam state_t POST_TX = BLANK;
`else
    localparam state_t POST_TX = ACQ;
`endif

    state_t             state, state_n, first_st;
    logic [1:0]         k, k_n;
    logic               accept, load, expire, last_scan, more_pulses;
    logic [CNT_W-1:0]   tlen;

    logic [CNT_W-1:0]   pl_s [N_PULSES_MAX];
    logic [CNT_W-1:0]   pd_s [N_PULSES_MAX];
    logic [CNT_W-1:0]   acq_s, rep_s;
    logic [1:0]         np_s;
    logic [SCAN_W-1:0]  ns_s;

    assign accept      = (state == IDLE) && start && !abort;
    assign first_st    = (np_s == 2'd0) ? POST_TX : PULSE;
    assign more_pulses = ({1'b0, k} + 3'd1) < {1'b0, np_s};
    assign last_scan   = ({1'b0, scan_count} + (SCAN_W+1)'(1)) >= {1'b0, ns_s};

    // Next-state, pulse index and timer load selection
    always_comb begin
        state_n = state;
        k_n     = k;
        case (state)
            IDLE:  if (accept) state_n = (n_scans == '0) ? DONE : ARM;
            ARM:   if (dds_valid) begin
                       state_n = first_st;
                       k_n     = 2'd0;
                   end
            PULSE: if (expire) state_n = PDLY;
            PDLY:  if (expire) begin
                       state_n = more_pulses ? PULSE : POST_TX;
                       k_n     = more_pulses ? k + 2'd1 : k;
                   end
            BLANK: if (expire) state_n = ACQ;
            ACQ:   if (expire) state_n = REP;
            REP:   if (expire) begin
                       state_n = last_scan ? DONE : first_st;
                       k_n     = 2'd0;
                   end
            DONE:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (abort && state != IDLE && state != DONE)
            state_n = DONE;
        load = (state_n != state) && is_timed(state_n);
        tlen = (state_n == PULSE) ? pl_s[k_n] :
               (state_n == PDLY)  ? pd_s[k_n] :
               (state_n == ACQ)   ? acq_s     :
               (state_n == REP)   ? rep_s     : CNT_W'(BLANK_CYCLES);
    end

    seq_timer #(.W(CNT_W)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (load),
        .len    (tlen),
        .expire (expire)
    );

    // Capture the run configuration when a start is accepted
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < N_PULSES_MAX; i++) begin
                pl_s[i] <= pulse_len[i*CNT_W +: CNT_W];
                pd_s[i] <= pulse_dly[i*CNT_W +: CNT_W];
            end
            acq_s <= acq_len;
            rep_s <= rep_dly;
            np_s  <= n_pulses;
            ns_s  <= n_scans;
        end
    end

    // State register and registered outputs decoded from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            k               <= 2'd0;
            enable_gen      <= 1'b0;
            TX_active_phase <= 2'd0;
            rx_gate         <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            scan_count      <= '0;
        end else begin
            state           <= state_n;
            k               <= k_n;
            enable_gen      <= (state_n == PULSE);
            TX_active_phase <= (state_n == PULSE) ? k_n :
                               (state_n == IDLE)  ? 2'd0 : TX_active_phase;
            rx_gate         <= (state_n == ACQ);
            busy            <= (state_n != IDLE);
            done            <= (state_n == DONE);
            scan_count      <= accept ? '0 :
                               (state == REP && expire && !abort) ? scan_count + SCAN_W'(1) : scan_count;
        end
    end

endmodule

// File: tb/tb_nmr_pulse_sequencer.sv
// tb_nmr_pulse_sequencer: table-driven and directed checks of the NMR pulse sequencer
module tb_nmr_pulse_sequencer;

`ifdef RX_BLANK_EN
    localparam int BLK = 16;
`else
    localparam int BLK = 0;
`endif

    typedef struct {
        int np, pl0, pl1, pl2, pd0, pd1, pd2, acq, rep, ns, poke;
        int e0, e1, e2, erx, ebz, esc;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst, start, abort, dds_valid;
    logic [1:0]  n_pulses;
    logic [95:0] pulse_len, pulse_dly;
    logic [31:0] acq_len, rep_dly;
    logic [15:0] n_scans;
    logic        enable_gen, rx_gate, busy, done;
    logic [1:0]  TX_active_phase;
    logic [15:0] scan_count;

    int n_tests = 0;
    int n_fail  = 0;
    vec_t vecs[7];

    nmr_pulse_sequencer dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .abort           (abort),
        .dds_valid       (dds_valid),
        .n_pulses        (n_pulses),
        .pulse_len       (pulse_len),
        .pulse_dly       (pulse_dly),
        .acq_len         (acq_len),
        .rep_dly         (rep_dly),
        .n_scans         (n_scans),
        .enable_gen      (enable_gen),
        .TX_active_phase (TX_active_phase),
        .rx_gate         (rx_gate),
        .busy            (busy),
        .done            (done),
        .scan_count      (scan_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        n_pulses  = 2'(v.np);
        pulse_len = {32'(v.pl2), 32'(v.pl1), 32'(v.pl0)};
        pulse_dly = {32'(v.pd2), 32'(v.pd1), 32'(v.pd0)};
        acq_len   = 32'(v.acq);
        rep_dly   = 32'(v.rep);
        n_scans   = 16'(v.ns);
    endtask

    task automatic kick();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int c = 0;
        while (!done && c < 3000) begin
            @(negedge clk);
            c++;
        end
        chk({nm, "_done"}, done, 1);
        @(negedge clk);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int en[4];
        int rx, bz, cyc;
        bit fin;
        apply(v);
        dds_valid = 1'b1;
        kick();
        en = '{0, 0, 0, 0};
        rx = 0; bz = 0; cyc = 0; fin = 1'b0;
        while (!fin && cyc < 3000) begin
            if (v.poke != 0 && cyc == 3) begin
                start = 1'b1;
                pulse_len[31:0] = 32'd40;
                n_scans = 16'd7;
                acq_len = 32'd99;
            end
            if (v.poke != 0 && cyc == 4) start = 1'b0;
            if (enable_gen) en[TX_active_phase]++;
            rx += int'(rx_gate);
            bz += int'(busy);
            fin = done;
            cyc++;
            @(negedge clk);
        end
        chk($sformatf("v%0d_done", idx), fin, 1);
        chk($sformatf("v%0d_en0", idx), en[0], v.e0);
        chk($sformatf("v%0d_en1", idx), en[1], v.e1);
        chk($sformatf("v%0d_en2", idx), en[2], v.e2);
        chk($sformatf("v%0d_rx", idx), rx, v.erx);
        chk($sformatf("v%0d_busy_cycles", idx), bz, v.ebz);
        chk($sformatf("v%0d_scan_count", idx), scan_count, v.esc);
        chk($sformatf("v%0d_busy_after_done", idx), busy, 0);
    endtask

    initial begin
        int c, g;
        bit bad;
        vecs[0] = '{2, 10, 20, 0, 7, 5, 0, 50, 8, 1, 0, 10, 20, 0, 50, 102 + BLK, 1};
        vecs[1] = '{1, 4, 0, 0, 3, 0, 0, 6, 2, 3, 0, 12, 0, 0, 18, 47 + 3*BLK, 3};
        vecs[2] = '{3, 1, 2, 3, 0, 2, 1, 0, 0, 2, 0, 2, 4, 6, 2, 26 + 2*BLK, 2};
        vecs[3] = '{0, 9, 9, 9, 9, 9, 9, 5, 3, 2, 0, 0, 0, 0, 10, 18 + 2*BLK, 2};
        vecs[4] = '{1, 5, 0, 0, 1, 0, 0, 5, 5, 0, 0, 0, 0, 0, 0, 1, 0};
        vecs[5] = '{1, 0, 0, 0, 2, 0, 0, 3, 0, 1, 0, 1, 0, 0, 3, 9 + BLK, 1};
        vecs[6] = '{1, 5, 0, 0, 2, 0, 0, 4, 1, 1, 1, 5, 0, 0, 4, 14 + BLK, 1};

        rst = 1'b1; start = 1'b0; abort = 1'b0; dds_valid = 1'b0;
        apply(vecs[0]);
        repeat (3) @(negedge clk);
        chk("rst_enable_gen", enable_gen, 0);
        chk("rst_phase", TX_active_phase, 0);
        chk("rst_rx_gate", rx_gate, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_scan_count", scan_count, 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

        // start and abort together in IDLE: abort wins
        @(negedge clk) begin start = 1'b1; abort = 1'b1; end
        @(negedge clk) begin start = 1'b0; abort = 1'b0; end
        chk("idle_abort_busy", busy, 0);
        chk("idle_abort_done", done, 0);

        // ARM waits for dds_valid
        apply(vecs[1]);
        dds_valid = 1'b0;
        kick();
        bad = 1'b0;
        repeat (30) begin
            if (enable_gen || !busy) bad = 1'b1;
            @(negedge clk);
        end
        chk("arm_hold", bad, 0);
        dds_valid = 1'b1;
        @(negedge clk);
        chk("arm_first_pulse", enable_gen, 1);
        chk("arm_first_phase", TX_active_phase, 0);
        wait_done("arm");

        // abort during ACQ of scan 2
        n_pulses = 2'd1; pulse_len = 96'd4; pulse_dly = 96'd2;
        acq_len = 32'd20; rep_dly = 32'd3; n_scans = 16'd3;
        kick();
        c = 0;
        while (!(rx_gate && scan_count == 16'd1) && c < 500) begin
            @(negedge clk);
            c++;
        end
        chk("abort_reach_acq2", rx_gate && scan_count == 16'd1, 1);
        repeat (5) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_rx_gate", rx_gate, 0);
        chk("abort_enable_gen", enable_gen, 0);
        chk("abort_done", done, 1);
        chk("abort_scan_count", scan_count, 1);
        @(negedge clk);
        chk("abort_done_once", done, 0);
        chk("abort_busy", busy, 0);
        chk("abort_scan_hold", scan_count, 1);

        // reset during PULSE of phase 1 in scan 2
        n_pulses = 2'd2;
        pulse_len = {32'd0, 32'd50, 32'd3};
        pulse_dly = {32'd0, 32'd1, 32'd2};
        acq_len = 32'd2; rep_dly = 32'd1; n_scans = 16'd2;
        kick();
        c = 0;
        while (!(enable_gen && TX_active_phase == 2'd1 && scan_count == 16'd1) && c < 500) begin
            @(negedge clk);
            c++;
        end
        chk("rstp_reach", enable_gen && TX_active_phase == 2'd1 && scan_count == 16'd1, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rstp_enable_gen", enable_gen, 0);
        chk("rstp_phase", TX_active_phase, 0);
        chk("rstp_rx_gate", rx_gate, 0);
        chk("rstp_busy", busy, 0);
        chk("rstp_done", done, 0);
        chk("rstp_scan_count", scan_count, 0);
        @(negedge clk);
        chk("rstp_stay_idle", busy, 0);

        // gap between last pulse and acquisition window
        n_pulses = 2'd1; pulse_len = 96'd3; pulse_dly = 96'd4;
        acq_len = 32'd5; rep_dly = 32'd1; n_scans = 16'd1;
        kick();
        c = 0;
        while (!enable_gen && c < 100) begin
            @(negedge clk);
            c++;
        end
        chk("gap_pulse_seen", enable_gen, 1);
        c = 0;
        while (enable_gen && c < 100) begin
            @(negedge clk);
            c++;
        end
        g = 0;
        while (!rx_gate && g < 100) begin
            g++;
            @(negedge clk);
        end
        chk("gap_before_acq", g, 4 + BLK);
        wait_done("gap");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
